// File: rtl/morse_char_buffer.sv
// Morse letter builder and letter FIFO between the button debouncers and the display consumers.
// Builds a dot/dash code (newest symbol in LSB) from button edges (MODE=0) or from the press
// length of a straight key (MODE=1), then queues finished letters in a DEPTH-entry FIFO.
// Ports: clk/reset (sync, active-high); dot/dash/send/key inputs; rd_en pops the head entry;
//   cur_code/cur_len show the letter being built; rd_code/rd_len show the head entry (zero when
//   empty); empty/full/count report FIFO occupancy; sym_err/ovf_err are sticky drop flags.
module morse_char_buffer #(
  parameter int MAX_SYMS    = 5,
  parameter int DEPTH       = 8,
  parameter int MODE        = 0,
  parameter int DASH_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 75_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dot,
  input  logic                           dash,
  input  logic                           send,
  input  logic                           key,
  input  logic                           rd_en,
  output logic [MAX_SYMS-1:0]            cur_code,
  output logic [$clog2(MAX_SYMS+1)-1:0]  cur_len,
  output logic [MAX_SYMS-1:0]            rd_code,
  output logic [$clog2(MAX_SYMS+1)-1:0]  rd_len,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           sym_err,
  output logic                           ovf_err
);
  localparam int LW = $clog2(MAX_SYMS + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = LW + MAX_SYMS;
  localparam int PW = $clog2(DASH_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [PW-1:0] DASH_MAX = PW'(DASH_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, GAP = 2'd2} key_state_e;

  key_state_e              state_q, state_d;
  logic [PW-1:0]           press_cnt_q, press_cnt_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic                    dot_q, dash_q, send_q;
  logic [MAX_SYMS-1:0]     cur_code_q, cur_code_d;
  logic [LW-1:0]           cur_len_q, cur_len_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    sym_err_q, sym_err_d, ovf_err_q, ovf_err_d;
  logic [EW-1:0]           mem_q [DEPTH];

  logic key_sym, key_bit, auto_send;
  logic send_ev, sym_ev, sym_bit, do_send, push, pop;

  // Straight-key timing FSM; held in IDLE when the button interface is selected.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    key_sym     = 1'b0;
    key_bit     = 1'b0;
    auto_send   = 1'b0;
    if (MODE == 1) begin
      case (state_q)
        IDLE: begin
          if (key) begin
            state_d     = PRESS;
            press_cnt_d = PW'(1);
          end
        end
        PRESS: begin
          if (key) begin
            if (press_cnt_q < DASH_MAX) press_cnt_d = press_cnt_q + PW'(1);
          end else begin
            key_sym   = 1'b1;
            key_bit   = (press_cnt_q >= DASH_MAX);
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
        GAP: begin
          if (key) begin
            state_d     = PRESS;
            press_cnt_d = PW'(1);
          end else if (cur_len_q == '0) begin
            // Letter already committed (or never started): nothing left to time out.
            state_d = IDLE;
          end else if (gap_cnt_q == GAP_LAST) begin
            auto_send = 1'b1;
            state_d   = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Letter assembly and FIFO bookkeeping.
  always_comb begin
    send_ev    = send && !send_q;
    sym_ev     = 1'b0;
    sym_bit    = 1'b0;
    if (MODE == 0) begin
      // Simultaneous dot and dash edges are ambiguous and cancel each other.
      sym_ev  = (dot && !dot_q) ^ (dash && !dash_q);
      sym_bit = dash && !dash_q;
    end else begin
      sym_ev  = key_sym;
      sym_bit = key_bit;
    end
    do_send    = send_ev || auto_send;
    pop        = rd_en && (count_q != '0);
    push       = 1'b0;
    cur_code_d = cur_code_q;
    cur_len_d  = cur_len_q;
    sym_err_d  = sym_err_q;
    ovf_err_d  = ovf_err_q;
    if (do_send) begin
      // A symbol arriving with the send is discarded rather than carried into the next letter.
      if (cur_len_q != '0) begin
        if ((count_q != CW'(DEPTH)) || pop) push = 1'b1;
        else                                  ovf_err_d = 1'b1;
      end
      cur_code_d = '0;
      cur_len_d  = '0;
    end else if (sym_ev) begin
      if (cur_len_q == LW'(MAX_SYMS)) begin
        sym_err_d = 1'b1;
      end else begin
        cur_code_d = {cur_code_q[MAX_SYMS-2:0], sym_bit};
        cur_len_d  = cur_len_q + LW'(1);
      end
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      dot_q       <= 1'b0;
      dash_q      <= 1'b0;
      send_q      <= 1'b0;
      cur_code_q  <= '0;
      cur_len_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sym_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      dot_q       <= dot;
      dash_q      <= dash;
      send_q      <= send;
      cur_code_q  <= cur_code_d;
      cur_len_q   <= cur_len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sym_err_q   <= sym_err_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  // Storage needs no reset: the read port is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {cur_len_q, cur_code_q};
  end

  assign cur_code = cur_code_q;
  assign cur_len  = cur_len_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign rd_code  = empty ? '0 : mem_q[rd_ptr_q][MAX_SYMS-1:0];
  assign rd_len   = empty ? '0 : mem_q[rd_ptr_q][EW-1:MAX_SYMS];
  assign sym_err  = sym_err_q;
  assign ovf_err  = ovf_err_q;
endmodule

// File: tb/tb_morse_char_buffer.sv
// Directed bench for morse_char_buffer: button-mode instance u0 (defaults) and
// straight-key instance u1 (DASH_CYCLES=4, GAP_CYCLES=6), sharing clock and reset.
module tb_morse_char_buffer;
  logic clk = 1'b0;
  logic reset;
  logic dot, dash, send, rd_en;
  logic key1;
  logic [4:0] cur_code0, rd_code0, cur_code1, rd_code1;
  logic [2:0] cur_len0, rd_len0, cur_len1, rd_len1;
  logic [3:0] count0, count1;
  logic empty0, full0, sym_err0, ovf_err0;
  logic empty1, full1, sym_err1, ovf_err1;

  int tests = 0;
  int fails = 0;
  int q_len[$];
  int q_code[$];

  always #5 clk = ~clk;

  morse_char_buffer u0 (
    .clk(clk), .reset(reset), .dot(dot), .dash(dash), .send(send), .key(1'b0), .rd_en(rd_en),
    .cur_code(cur_code0), .cur_len(cur_len0), .rd_code(rd_code0), .rd_len(rd_len0),
    .empty(empty0), .full(full0), .count(count0), .sym_err(sym_err0), .ovf_err(ovf_err0)
  );

  morse_char_buffer #(.MODE(1), .DASH_CYCLES(4), .GAP_CYCLES(6)) u1 (
    .clk(clk), .reset(reset), .dot(1'b0), .dash(1'b0), .send(1'b0), .key(key1), .rd_en(1'b0),
    .cur_code(cur_code1), .cur_len(cur_len1), .rd_code(rd_code1), .rd_len(rd_len1),
    .empty(empty1), .full(full1), .count(count1), .sym_err(sym_err1), .ovf_err(ovf_err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic d, input logic h, input logic s);
    dot = d; dash = h; send = s;
    tick();
    dot = 1'b0; dash = 1'b0; send = 1'b0;
    tick();
  endtask

  // First symbol lands in bit len-1 of the code.
  task automatic enter_syms(input int len, input logic [31:0] code);
    for (int i = len - 1; i >= 0; i--) pulse(!code[i], code[i], 1'b0);
  endtask

  task automatic add_letter(input int len, input logic [31:0] code);
    enter_syms(len, code);
    pulse(1'b0, 1'b0, 1'b1);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain_and_check();
    while (q_len.size() > 0) begin
      check("drain_len", rd_len0, q_len[0]);
      check("drain_code", rd_code0, q_code[0]);
      void'(q_len.pop_front());
      void'(q_code.pop_front());
      pop_one();
    end
    check("drain_empty", empty0, 1);
  endtask

  initial begin
    int len;
    int code;
    reset = 1'b1; dot = 1'b0; dash = 1'b0; send = 1'b0; rd_en = 1'b0; key1 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_empty", empty0, 1);
    check("rst_full", full0, 0);
    check("rst_count", count0, 0);
    check("rst_cur_len", cur_len0, 0);
    check("rst_rd_len", rd_len0, 0);
    check("rst_errs", {sym_err0, ovf_err0}, 0);

    // dot, dash, dash, send
    enter_syms(3, 32'b011);
    check("b_cur_code", cur_code0, 5'b00011);
    check("b_cur_len", cur_len0, 3);
    pulse(1'b0, 1'b0, 1'b1);
    check("b_rd_len", rd_len0, 3);
    check("b_rd_code", rd_code0, 5'b00011);
    check("b_count", count0, 1);
    check("b_cur_len0", cur_len0, 0);
    check("b_empty", empty0, 0);
    pop_one();
    check("pop_count", count0, 0);
    check("pop_rd_code", rd_code0, 0);

    // Held level counts once
    dot = 1'b1; tick(); tick(); tick(); dot = 1'b0; tick();
    check("held_len", cur_len0, 1);
    pulse(1'b0, 1'b0, 1'b1);
    pop_one();

    // Empty send and empty pop
    pulse(1'b0, 1'b0, 1'b1);
    pop_one();
    check("nop_count", count0, 0);
    check("nop_empty", empty0, 1);
    check("nop_errs", {sym_err0, ovf_err0}, 0);

    // Simultaneous dot and dash
    pulse(1'b1, 1'b1, 1'b0);
    check("dd_len", cur_len0, 0);
    check("dd_sym_err", sym_err0, 0);

    // Send with a symbol edge: symbol discarded
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1);
    check("sw_rd_len", rd_len0, 1);
    check("sw_rd_code", rd_code0, 0);
    check("sw_cur_len", cur_len0, 0);
    pop_one();

    // Six dots: sixth dropped
    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, 1'b0);
    check("sat_len", cur_len0, 5);
    check("sat_code", cur_code0, 0);
    check("sat_sym_err", sym_err0, 1);
    pulse(1'b0, 1'b0, 1'b1);
    check("sat_rd_len", rd_len0, 5);
    check("sat_rd_code", rd_code0, 0);
    pop_one();

    // Fill the FIFO
    for (int k = 0; k < 8; k++) begin
      len = (k % 4) + 1;
      code = k & ((1 << len) - 1);
      add_letter(len, code);
      q_len.push_back(len);
      q_code.push_back(code);
    end
    check("fill_full", full0, 1);
    check("fill_count", count0, 8);
    check("fill_ovf", ovf_err0, 0);
    add_letter(2, 32'b10);
    check("ovf_err", ovf_err0, 1);
    check("ovf_count", count0, 8);
    check("ovf_cur_len", cur_len0, 0);

    // Push and pop together while full
    enter_syms(2, 32'b11);
    send = 1'b1; rd_en = 1'b1;
    tick();
    send = 1'b0; rd_en = 1'b0;
    tick();
    void'(q_len.pop_front());
    void'(q_code.pop_front());
    q_len.push_back(2);
    q_code.push_back(3);
    check("pp_count", count0, 8);
    check("pp_full", full0, 1);
    drain_and_check();

    // Reset mid-letter with three queued
    add_letter(1, 32'b1);
    add_letter(2, 32'b01);
    add_letter(3, 32'b110);
    pulse(1'b1, 1'b0, 1'b0);
    check("pre_rst_count", count0, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_count", count0, 0);
    check("mr_empty", empty0, 1);
    check("mr_full", full0, 0);
    check("mr_cur", {cur_len0, cur_code0}, 0);
    check("mr_rd", {rd_len0, rd_code0}, 0);
    check("mr_errs", {sym_err0, ovf_err0}, 0);

    // Straight key: high 2, low 2, high 5, low until auto-send
    key1 = 1'b1; tick(); tick();
    key1 = 1'b0; tick();
    check("k_dot_len", cur_len1, 1);
    check("k_dot_code", cur_code1, 0);
    tick();
    key1 = 1'b1; repeat (5) tick();
    key1 = 1'b0; repeat (6) tick();
    check("k_cur_len", cur_len1, 2);
    check("k_cur_code", cur_code1, 5'b00001);
    check("k_not_yet", count1, 0);
    tick();
    check("k_count", count1, 1);
    check("k_rd_len", rd_len1, 2);
    check("k_rd_code", rd_code1, 5'b00001);
    check("k_cur_clr", cur_len1, 0);
    check("k_state", 32'(u1.state_q), 0);
    check("k_errs", {sym_err1, ovf_err1}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
